// File: rtl/aska_spi_master.sv
// aska_spi_master: SPI mode-0 master that emits ASKA configuration frames.
// A frame is one command byte {ic_addr, reg_addr} followed by a 32-bit data
// word, 40 bits MSB first, framed by SPI_CS with programmable setup, hold and
// inter-frame gap.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start                 frame request, sampled only while idle
//   abort                 truncate the current frame after the bit in flight
//   ic_addr, reg_addr     command byte fields (bits [7:6] and [5:0])
//   data                  32-bit payload
//   busy, done, frame_ok  host handshake / status
//   SPI_CS, SPI_Clk, SPI_MOSI  serial link to the ASKA chips
module aska_spi_master #(
  parameter int unsigned HALF_DIV = 4,
  parameter int unsigned CS_SETUP = 8,
  parameter int unsigned CS_HOLD  = 8,
  parameter int unsigned IDLE_GAP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  ic_addr,
  input  logic [5:0]  reg_addr,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        frame_ok,
  output logic        SPI_CS,
  output logic        SPI_Clk,
  output logic        SPI_MOSI
);

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned BCNT_W     = 6;

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);
  localparam logic [BCNT_W-1:0] BITS_ALL  = BCNT_W'(FRAME_BITS);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_LOW   = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  logic [2:0]              state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [FRAME_BITS-1:0]   shift, shift_nxt;
  logic [BCNT_W-1:0]       bit_cnt, bit_cnt_nxt;
  logic                    abort_pend, abort_pend_nxt;
  logic                    abort_any;
  logic                    frame_ok_nxt;
  logic                    busy_nxt, done_nxt, cs_nxt, sclk_nxt, mosi_nxt;

  // Next-state, datapath and next-output computation
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + CNT_W'(1);
    shift_nxt      = shift;
    bit_cnt_nxt    = bit_cnt;
    abort_pend_nxt = abort_pend;
    frame_ok_nxt   = frame_ok;
    abort_any      = abort_pend | abort;

    case (state)
      ST_IDLE: begin
        cnt_nxt        = '0;
        abort_pend_nxt = 1'b0;
        if (start) begin
          shift_nxt    = {ic_addr, reg_addr, data};
          bit_cnt_nxt  = '0;
          frame_ok_nxt = 1'b0;
          state_nxt    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Abort before any clock edge: skip straight to the CS hold phase
        if (abort) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end else if (cnt == SETUP_LAST) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
        end
      end
      ST_LOW: begin
        if (abort) abort_pend_nxt = 1'b1;
        if (cnt == HALF_LAST) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
        end
      end
      ST_HIGH: begin
        // The bit in flight always completes its high phase
        abort_pend_nxt = abort_any;
        if (cnt == HALF_LAST) begin
          cnt_nxt     = '0;
          bit_cnt_nxt = bit_cnt + BCNT_W'(1);
          shift_nxt   = {shift[FRAME_BITS-2:0], 1'b0};
          if ((bit_cnt_nxt == BITS_ALL) || abort_any) begin
            state_nxt    = ST_HOLD;
            frame_ok_nxt = (bit_cnt_nxt == BITS_ALL);
          end else begin
            state_nxt = ST_LOW;
          end
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Pin values are derived from the next state so they register in step with it
    busy_nxt = (state_nxt != ST_IDLE);
    cs_nxt   = !((state_nxt == ST_SETUP) || (state_nxt == ST_LOW) ||
                 (state_nxt == ST_HIGH)  || (state_nxt == ST_HOLD));
    sclk_nxt = (state_nxt == ST_HIGH);
    mosi_nxt = ((state_nxt == ST_SETUP) || (state_nxt == ST_LOW) ||
                (state_nxt == ST_HIGH)) ? shift_nxt[FRAME_BITS-1] : 1'b0;
    done_nxt = (state_nxt == ST_GAP) && (cnt_nxt == GAP_LAST);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      abort_pend <= 1'b0;
      frame_ok   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      SPI_CS     <= 1'b1;
      SPI_Clk    <= 1'b0;
      SPI_MOSI   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shift      <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      abort_pend <= abort_pend_nxt;
      frame_ok   <= frame_ok_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      SPI_CS     <= cs_nxt;
      SPI_Clk    <= sclk_nxt;
      SPI_MOSI   <= mosi_nxt;
    end
  end

endmodule

// File: tb/tb_aska_spi_master.sv
// Directed bench for aska_spi_master: default-parameter instance plus a
// minimum-parameter instance, with a negedge link monitor per instance.
module tb_aska_spi_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [1:0]  ic_addr = '0;
  logic [5:0]  reg_addr = '0;
  logic [31:0] data = '0;
  logic        busy, done, frame_ok, spi_cs, spi_clk, spi_mosi;

  logic        m_start = 1'b0;
  logic [1:0]  m_ic = '0;
  logic [5:0]  m_reg = '0;
  logic [31:0] m_data = '0;
  logic        m_busy, m_done, m_frame_ok, m_cs, m_clk, m_mosi;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aska_spi_master dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ic_addr(ic_addr), .reg_addr(reg_addr), .data(data),
    .busy(busy), .done(done), .frame_ok(frame_ok),
    .SPI_CS(spi_cs), .SPI_Clk(spi_clk), .SPI_MOSI(spi_mosi)
  );

  aska_spi_master #(.HALF_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .IDLE_GAP(1)) dut_min (
    .clk(clk), .reset(reset), .start(m_start), .abort(1'b0),
    .ic_addr(m_ic), .reg_addr(m_reg), .data(m_data),
    .busy(m_busy), .done(m_done), .frame_ok(m_frame_ok),
    .SPI_CS(m_cs), .SPI_Clk(m_clk), .SPI_MOSI(m_mosi)
  );

  // Link monitor, default instance
  logic        p_cs = 1'b1, p_clk = 1'b0, p_mosi = 1'b0;
  logic [39:0] rx = '0, f_rx = '0;
  int rises = 0, f_rises = 0, low_acc = 0, f_len = 0, falls = 0, glitch = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, first_rise_cyc = 0;
  int done_cnt = 0, done_cyc = 0;
  logic ok_at_done = 1'b0;

  always @(negedge clk) begin
    if (!spi_cs && p_cs) begin
      cs_fall_cyc <= cyc; rx <= '0; rises <= 0; low_acc <= 1; falls <= falls + 1;
    end else if (!spi_cs) begin
      low_acc <= low_acc + 1;
    end
    if (spi_cs && !p_cs) begin
      cs_rise_cyc <= cyc; f_rx <= rx; f_rises <= rises; f_len <= low_acc;
    end
    if (spi_clk && !p_clk) begin
      rx <= {rx[38:0], spi_mosi};
      rises <= rises + 1;
      if (rises == 0) first_rise_cyc <= cyc;
    end
    if (spi_clk && p_clk && (spi_mosi != p_mosi)) glitch <= glitch + 1;
    if (done) begin
      done_cnt <= done_cnt + 1; done_cyc <= cyc; ok_at_done <= frame_ok;
    end
    p_cs <= spi_cs; p_clk <= spi_clk; p_mosi <= spi_mosi;
  end

  // Link monitor, minimum-parameter instance
  logic        mp_cs = 1'b1, mp_clk = 1'b0;
  logic [39:0] m_rx = '0, mf_rx = '0;
  int m_low_acc = 0, mf_len = 0, mf_rises = 0, m_rises = 0, m_done_cnt = 0, m_done_cyc = 0;
  logic m_ok_at_done = 1'b0;

  always @(negedge clk) begin
    if (!m_cs && mp_cs) begin
      m_rx <= '0; m_rises <= 0; m_low_acc <= 1;
    end else if (!m_cs) begin
      m_low_acc <= m_low_acc + 1;
    end
    if (m_cs && !mp_cs) begin
      mf_rx <= m_rx; mf_len <= m_low_acc; mf_rises <= m_rises;
    end
    if (m_clk && !mp_clk) begin
      m_rx <= {m_rx[38:0], m_mosi};
      m_rises <= m_rises + 1;
    end
    if (m_done) begin
      m_done_cnt <= m_done_cnt + 1; m_done_cyc <= cyc; m_ok_at_done <= m_frame_ok;
    end
    mp_cs <= m_cs; mp_clk <= m_clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // All stimulus and sampling happens just after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int x);
    while (cyc < x) tick();
  endtask

  task automatic wait_done(input int n0, input string tag);
    int k = 0;
    while (done_cnt == n0 && k < 3000) begin
      tick();
      k++;
    end
    check(tag, 64'(done_cnt - n0), 64'd1);
  endtask

  task automatic send(input logic [1:0] ic, input logic [5:0] rg, input logic [31:0] d,
                      output int t);
    t        = cyc;
    ic_addr  = ic;
    reg_addr = rg;
    data     = d;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  logic [39:0] full;
  int t, n0, f0, k;

  initial begin
    repeat (3) tick();
    check("reset_outputs", {58'd0, spi_cs, spi_clk, spi_mosi, busy, done, frame_ok},
          {58'd0, 6'b100000});
    check("reset_outputs_min", {58'd0, m_cs, m_clk, m_mosi, m_busy, m_done, m_frame_ok},
          {58'd0, 6'b100000});
    reset = 1'b0;
    repeat (3) tick();

    // Full frame with default timing
    n0 = done_cnt;
    send(2'd3, 6'd0, 32'hAABBCCDD, t);
    check("full_busy_t1", {62'd0, busy, spi_cs}, {62'd0, 2'b10});
    wait_cyc(t + 13);
    check("full_first_rise", 64'(first_rise_cyc), 64'(t + 13));
    wait_done(n0, "full_done_seen");
    check("full_done_cyc", 64'(done_cyc), 64'(t + 340));
    check("full_bits", 64'(f_rx), 64'hC0AABBCCDD);
    check("full_rises", 64'(f_rises), 64'd40);
    check("full_cs_len", 64'(f_len), 64'd336);
    check("full_cs_fall", 64'(cs_fall_cyc), 64'(t + 1));
    check("full_cs_rise", 64'(cs_rise_cyc), 64'(t + 337));
    check("full_frame_ok", 64'(ok_at_done), 64'd1);
    tick();
    check("full_busy_clear", {63'd0, busy}, 64'd0);
    check("full_mosi_stable", 64'(glitch), 64'd0);

    // Abort during the low phase of bit 32
    repeat (4) tick();
    n0 = done_cnt;
    send(2'd3, 6'd3, 32'h554466AA, t);
    wait_cyc(t + 266);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(n0, "abort_done_seen");
    full = 40'hC3554466AA;
    check("abort_rises", 64'(f_rises), 64'd33);
    check("abort_bits", 64'(f_rx), 64'(full >> 7));
    check("abort_cs_len", 64'(f_len), 64'd280);
    check("abort_frame_ok", 64'(ok_at_done), 64'd0);
    repeat (4) tick();
    n0 = done_cnt;
    send(2'd3, 6'd1, 32'h3377EEFF, t);
    wait_done(n0, "after_abort_done_seen");
    check("after_abort_bits", 64'(f_rx), 64'hC13377EEFF);
    check("after_abort_ok", 64'(ok_at_done), 64'd1);

    // Back-to-back frames with start held high
    repeat (4) tick();
    n0 = done_cnt;
    t = cyc;
    ic_addr = 2'd3; reg_addr = 6'd2; data = 32'hBEBECACA; start = 1'b1;
    tick();
    reg_addr = 6'd3; data = 32'hCAFEBABA;
    wait_done(n0, "b2b_first_done_seen");
    check("b2b_first_bits", 64'(f_rx), 64'hC2BEBECACA);
    check("b2b_first_done_cyc", 64'(done_cyc), 64'(t + 340));
    wait_cyc(t + 342);
    start = 1'b0;
    check("b2b_second_fall", 64'(cs_fall_cyc), 64'(t + 342));
    check("b2b_cs_high_gap", 64'(cs_fall_cyc - cs_rise_cyc), 64'd5);
    n0 = done_cnt;
    wait_done(n0, "b2b_second_done_seen");
    check("b2b_second_bits", 64'(f_rx), 64'hC3CAFEBABA);

    // Start and data changes while busy are ignored
    repeat (4) tick();
    n0 = done_cnt;
    f0 = falls;
    send(2'd1, 6'd0, 32'h0F0F1234, t);
    wait_cyc(t + 100);
    start = 1'b1; data = 32'hFFFFFFFF; ic_addr = 2'd0;
    tick();
    start = 1'b0;
    wait_done(n0, "iso_done_seen");
    check("iso_bits", 64'(f_rx), 64'h400F0F1234);
    repeat (400) tick();
    check("iso_frame_count", 64'(falls - f0), 64'd1);

    // Reset during bit 17 high phase
    n0 = done_cnt;
    send(2'd2, 6'd2, 32'h13572468, t);
    wait_cyc(t + 150);
    check("rst_clk_high", {63'd0, spi_clk}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_outputs", {60'd0, spi_cs, spi_clk, busy, done}, {60'd0, 4'b1000});
    repeat (20) tick();
    check("rst_no_done", 64'(done_cnt), 64'(n0));
    n0 = done_cnt;
    send(2'd0, 6'd1, 32'hDEADBEEF, t);
    wait_done(n0, "post_rst_done_seen");
    check("post_rst_bits", 64'(f_rx), 64'hC0 & 64'h0 | 64'h01DEADBEEF);
    check("post_rst_cs_len", 64'(f_len), 64'd336);

    // Minimum timing parameters
    repeat (4) tick();
    n0 = m_done_cnt;
    t = cyc;
    m_ic = 2'd3; m_reg = 6'd2; m_data = 32'h12345678; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    k = 0;
    while (m_done_cnt == n0 && k < 500) begin
      tick();
      k++;
    end
    check("min_done_seen", 64'(m_done_cnt - n0), 64'd1);
    check("min_done_cyc", 64'(m_done_cyc), 64'(t + 83));
    check("min_bits", 64'(mf_rx), 64'hC212345678);
    check("min_rises", 64'(mf_rises), 64'd40);
    check("min_cs_len", 64'(mf_len), 64'd82);
    check("min_frame_ok", 64'(m_ok_at_done), 64'd1);
    tick();
    check("min_busy_clear", {63'd0, m_busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aska_spi_master.md
# aska_spi_master

SPI master that produces ASKA configuration frames: the initiator end of the link that the `aska_spi` slave receives. Each frame holds one command byte, made of a 2-bit IC address and a 6-bit register select, followed by a 32-bit data word. All bits go out MSB first in SPI mode 0. The block sits in the controller/FPGA-side design, is driven by a host sequencer through a start/busy/done handshake, and fans out `SPI_CS`/`SPI_Clk`/`SPI_MOSI` to one or more ASKA chips.

## Interface
Parameters:
- `HALF_DIV`, 4: `clk` cycles per SPI_Clk half-period (≥1).
- `CS_SETUP`, 8: `clk` cycles from the SPI_CS falling edge to the first SPI_Clk low phase (≥1).
- `CS_HOLD`, 8: `clk` cycles from the last SPI_Clk falling edge to the SPI_CS rising edge (≥1).
- `IDLE_GAP`, 4: minimum `clk` cycles SPI_CS stays high between frames (≥1).

Ports:
- `clk`, in, 1: system clock. One clock only.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a frame. Sampled only when `busy`=0.
- `abort`, in, 1: terminate the current frame early.
- `ic_addr`, in, 2: chip address, sent in command bits [7:6].
- `reg_addr`, in, 6: register select, sent in command bits [5:0] (0=conf0, 1=conf1, 2=ele1, 3=ele2).
- `data`, in, 32: payload word.
- `busy`, out, 1: a frame is in progress.
- `done`, out, 1: one-cycle pulse at the end of a frame.
- `frame_ok`, out, 1: the last frame sent all 40 bits. Valid from `done` until the next start.
- `SPI_CS`, out, 1: chip select, active low.
- `SPI_Clk`, out, 1: SPI clock, idles low.
- `SPI_MOSI`, out, 1: serial data out.

## Operation
- Reset values: `SPI_CS`=1, `SPI_Clk`=0, `SPI_MOSI`=0, `busy`=0, `done`=0, `frame_ok`=0. Reset also puts the FSM in IDLE.
- FSM states: IDLE → SETUP → LOW ⇄ HIGH → HOLD → GAP → IDLE.
- IDLE:
  - If `start`=1, latch the 40-bit shift register = {ic_addr, reg_addr, data}.
  - Clear `frame_ok` and go to SETUP.
  - `abort` is ignored in IDLE.
- SETUP:
  - `SPI_CS`=0, `SPI_Clk`=0, `SPI_MOSI`=shift[39].
  - Lasts `CS_SETUP` cycles, then goes to LOW.
- LOW:
  - `SPI_Clk`=0 and `SPI_MOSI` presents the current bit. Lasts `HALF_DIV` cycles, then goes to HIGH.
- HIGH:
  - `SPI_Clk`=1 for `HALF_DIV` cycles, during which `SPI_MOSI` is held stable.
  - On exit, increment the 6-bit bit counter (0..39) and shift left.
  - If 40 bits have been sent or an abort is pending, go to HOLD; otherwise go to LOW.
  - The next bit appears on `SPI_MOSI` in the same cycle that `SPI_Clk` falls.
- HOLD:
  - `SPI_Clk`=0, `SPI_CS`=0 for `CS_HOLD` cycles, then go to GAP.
  - `frame_ok` is set to 1 only if the bit counter reached 40.
- GAP:
  - `SPI_CS`=1 and `SPI_MOSI`=0 for `IDLE_GAP` cycles.
  - `done`=1 in the last GAP cycle, then go to IDLE.
- Abort:
  - `abort`=1 during SETUP/LOW/HIGH sets a pending flag.
  - From SETUP: go directly to HOLD, with 0 bits sent.
  - From LOW/HIGH: the current bit's HIGH phase completes, then HOLD.
  - This produces deliberately truncated frames; the slave must discard them.
- Input isolation:
  - `start` while `busy`=1 is ignored.
  - `ic_addr`/`reg_addr`/`data` changes after the latch have no effect.
- Reset mid-frame: on the next edge all outputs take their reset values. No `done` pulse is produced, and no partial SPI_Clk pulse beyond that edge.

## Timing
- `start` is sampled at edge T.
- `busy`=1 and `SPI_CS`=0 from cycle T+1.
- CS-low length, full frame: `CS_SETUP` + 80·`HALF_DIV` + `CS_HOLD` cycles. With defaults this is 336, spanning T+1..T+336.
- With defaults:
  - `SPI_CS` rises at T+337.
  - `done` pulses at T+340.
  - `busy`=0 from T+341.
  - The earliest next start is sampled at T+341, giving the next SPI_CS fall at T+342.
- Bit k (k=0 is MSB of the command) has its SPI_Clk rising edge at cycle T+1+`CS_SETUP`+(2k+1)·`HALF_DIV`.
- `SPI_MOSI` is stable for ≥`HALF_DIV` cycles before and after each rising edge.
- All outputs are registered, so the SPI pins have no combinational paths from inputs.

## Test plan
- **Full frame:** ic_addr=3, reg_addr=0, data=0xAABBCCDD, defaults → MOSI sampled on SPI_Clk rising edges = C0 AA BB CC DD; 40 rising edges; CS low 336 cycles; `done` at T+340; `frame_ok`=1. An attached `aska_spi` slave with IC_addr=3 gives conf0=0xAABBCCDD.
- **Abort:** reg_addr=3, data=0x554466AA, `abort` pulsed during bit 32 LOW → 33 rising edges, then HOLD/GAP; `frame_ok`=0; slave ele2 unchanged. A following frame reg 1, data 0x3377EEFF → conf1=0x3377EEFF.
- **Back-to-back:** `start` held high for frames c2/BEBECACA and c3/CAFEBABA → second SPI_CS fall at T+342; CS high for exactly 5 cycles between frames; ele1=0xBEBECACA, ele2=0xCAFEBABA.
- **Busy/isolation:** pulse `start` and toggle `data` mid-frame → no extra frame; transmitted data equals the value latched at T.
- **Reset mid-frame:** assert `reset` during bit 17 → next cycle SPI_CS=1, SPI_Clk=0, busy=0, no `done`; the subsequent frame is bit-exact.
- **Minimum parameters:** HALF_DIV=1, CS_SETUP=CS_HOLD=IDLE_GAP=1; frame c2/0x12345678 → CS low 82 cycles; correct bitstream.
